// File: rtl/lockpick_uart_tx.sv
// -----------------------------------------------------------------------------
// lockpick_uart_tx
//
// Serializer for the lockpick game's result-message burst. Bytes arrive at up
// to one per clock, are buffered in a FIFO and are sent out as 8N1 UART frames
// (start bit, 8 data bits LSB first, stop bit) on a single registered pin.
//
// Optional feature (compile-time macro LOCKPICK_TX_STATUS_HDR_EN):
//   When defined, every burst is prefixed with the header byte
//   {6'b101000, status}. All data bytes then pass through a one-stage delay
//   register so the header can take the burst's first write slot.
//   When undefined, bytes are written in their arrival cycle and status is
//   unused.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   DEPTH         FIFO entries (power of two, >= 33)
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    byte strobe from the game
//   in_data     byte from the game
//   status      game status, used only for the header byte
//   tx          UART line, registered, idles high
//   busy        FIFO non-empty, transmitter active, or header pipeline loaded
//   overflow    sticky; set when a write is dropped because the FIFO is full
//   fifo_level  current FIFO occupancy
// -----------------------------------------------------------------------------
module lockpick_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DEPTH        = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic [1:0]               status,
  output logic                     tx,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE    = BW'(1);
  localparam logic [AW:0]   LEVEL_FULL  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LEVEL_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE     = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  logic       wr_en;
  logic [7:0] wr_data;
  logic       pipe_busy;

`ifdef LOCKPICK_TX_STATUS_HDR_EN
  logic       dly_valid;
  logic [7:0] dly_data;
  logic       burst_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_valid <= 1'b0;
      dly_data  <= '0;
    end else begin
      dly_valid <= in_valid;
      dly_data  <= in_data;
    end
  end

  // A burst start needs in_valid low on the previous cycle, which is exactly
  // when the delay stage is empty, so header and delayed data never collide.
  assign burst_start = in_valid & ~dly_valid;

  always_comb begin
    wr_en   = burst_start | dly_valid;
    wr_data = burst_start ? {6'b101000, status} : dly_data;
  end

  assign pipe_busy = dly_valid;
`else
  logic unused_status;
  assign unused_status = ^status;

  always_comb begin
    wr_en   = in_valid;
    wr_data = in_data;
  end

  assign pipe_busy = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          push;
  logic [7:0]    head;
  state_t        state;

  assign full = (count == LEVEL_FULL);
  assign pop  = (state == S_IDLE) && (count != '0);
  // The pop is considered first, so a write at full succeeds when a pop
  // happens in the same cycle.
  assign push = wr_en && (!full || pop);
  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + LEVEL_ONE;
        2'b01:   count <= count - LEVEL_ONE;
        default: count <= count;
      endcase
      if (wr_en && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  assign fifo_level = count;

  // ---------------------------------------------------------------------------
  // Transmitter FSM
  // tx is registered from the current state, so the line lags the state by
  // one cycle; every bit still lasts CLKS_PER_BIT cycles.
  // ---------------------------------------------------------------------------
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      busy <= (count != '0) || (state != S_IDLE) || pipe_busy;
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg   <= head;
            bit_idx <= '0;
            baud    <= BAUD_RELOAD;
            state   <= S_START;
          end
        end
        S_START: begin
          tx <= 1'b0;
          if (baud == '0) begin
            baud  <= BAUD_RELOAD;
            state <= S_DATA;
          end else begin
            baud <= baud - BAUD_ONE;
          end
        end
        S_DATA: begin
          tx <= shreg[0];
          if (baud == '0) begin
            baud  <= BAUD_RELOAD;
            shreg <= {1'b0, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud <= baud - BAUD_ONE;
          end
        end
        S_STOP: begin
          tx <= 1'b1;
          if (baud == '0) begin
            state <= S_IDLE;
          end else begin
            baud <= baud - BAUD_ONE;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lockpick_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_lockpick_uart_tx
//
// Scoreboard bench for lockpick_uart_tx (CLKS_PER_BIT=4, DEPTH=64). A
// cycle-level reference model turns the byte strobes into FIFO writes, pops
// and expected frames (data byte plus the cycle the start bit must appear);
// a monitor decodes the tx line and compares each frame against the queue.
// Build with LOCKPICK_TX_STATUS_HDR_EN defined to exercise the header feature.
// -----------------------------------------------------------------------------
module tb_lockpick_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 64;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [1:0] status = '0;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [6:0] fifo_level;

  always #5 clk = ~clk;

  lockpick_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .status(status),
    .tx(tx),
    .busy(busy),
    .overflow(overflow),
    .fifo_level(fifo_level)
  );

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] mq[$];
  int         cyc = 0;
  int         timer = 0;
  bit         ovf_exp = 1'b0;
  bit         prev_v = 1'b0;
  logic [7:0] prev_d = '0;
  int         model_peak = 0;
  int         dut_peak = 0;
  int         checks = 0;
  int         failures = 0;
  bit         mon_en = 1'b0;
  bit         mon_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: per edge, the FIFO pops first (whenever the transmitter
  // has been free for a full frame plus one idle cycle), then the write lands
  // if there is room.
  logic       m_wr;
  logic [7:0] m_wd;
  frame_t     m_fr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      timer   = 0;
      ovf_exp = 1'b0;
      prev_v  = 1'b0;
    end else begin
      cyc++;
      m_wr = 1'b0;
      m_wd = '0;
`ifdef LOCKPICK_TX_STATUS_HDR_EN
      if (in_valid && !prev_v) begin
        m_wr = 1'b1;
        m_wd = {6'b101000, status};
      end else if (prev_v) begin
        m_wr = 1'b1;
        m_wd = prev_d;
      end
      prev_v = in_valid;
      prev_d = in_data;
`else
      if (in_valid) begin
        m_wr = 1'b1;
        m_wd = in_data;
      end
`endif
      if (timer > 0) timer--;
      if (timer == 0 && mq.size() > 0) begin
        m_fr.data  = mq.pop_front();
        m_fr.start = cyc + 1;
        exp_q.push_back(m_fr);
        timer = FRAME + 1;
      end
      if (m_wr) begin
        if (mq.size() < DEPTH) mq.push_back(m_wd);
        else ovf_exp = 1'b1;
      end
      if (mq.size() > model_peak) model_peak = mq.size();
    end
  end

  // Level / overflow tracking every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("fifo_level", 32'(fifo_level), 32'(mq.size()));
        check("overflow", 32'(overflow), 32'(ovf_exp));
        if (int'(fifo_level) > dut_peak) dut_peak = int'(fifo_level);
      end
    end
  end

  // Frame monitor: decodes the line mid-bit and pops the scoreboard.
  initial begin
    logic [7:0] b;
    int         c;
    logic       sb;
    logic       pb;
    frame_t     e;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tx === 1'b0) begin
        mon_busy = 1'b1;
        c = cyc;
        repeat (CPB / 2) @(negedge clk);
        sb = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        pb = tx;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame: got 0x%0h required no frame (t=%0t)", b, $time);
        end else begin
          e = exp_q.pop_front();
          check("frame_data", 32'(b), 32'(e.data));
          check("frame_start_cycle", 32'(c), 32'(e.start));
          check("start_bit", 32'(sb), 32'h0);
          check("stop_bit", 32'(pb), 32'h1);
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic send_burst(input int n, input logic [1:0] st, input int kind);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      status   = st;
      case (kind)
        0:       in_data = (i % 2 == 0) ? 8'hCE : 8'hFA;
        1:       in_data = (i % 2 == 0) ? 8'hDE : 8'hAD;
        default: in_data = 8'($urandom);
      endcase
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || mq.size() != 0 || mon_busy || prev_v) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_timeout"}, 32'(n >= 20000), 32'h0);
    repeat (4) @(negedge clk);
    check({name, "_busy_idle"}, 32'(busy), 32'h0);
    check({name, "_tx_idle"}, 32'(tx), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_tx", 32'(tx), 32'h1);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_overflow", 32'(overflow), 32'h0);
    check("reset_level", 32'(fifo_level), 32'h0);

    // Reset mid-frame: line must return high without a clock edge
    send_burst(1, 2'b00, 2);
    repeat (3) @(negedge clk);
    check("pre_reset_tx_low", 32'(tx), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_tx", 32'(tx), 32'h1);
    check("async_reset_level", 32'(fifo_level), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_level", 32'(fifo_level), 32'h0);
    check("post_reset_busy", 32'(busy), 32'h0);
    check("post_reset_overflow", 32'(overflow), 32'h0);
    mon_en = 1'b1;

    // Single byte 0xA5
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("single_busy_mid_frame", 32'(busy), 32'h1);
    wait_drain("single");

    // FACEFACE burst
    model_peak = 0;
    dut_peak   = 0;
    send_burst(32, 2'b00, 0);
    wait_drain("face_burst");
    check("face_burst_peak", 32'(dut_peak), 32'(model_peak));

    // 0xDE/0xAD burst with status 10 (header 0xA2 when enabled)
    model_peak = 0;
    dut_peak   = 0;
    send_burst(32, 2'b10, 1);
    wait_drain("dead_burst");
    check("dead_burst_peak", 32'(dut_peak), 32'(model_peak));

    // Back-to-back bursts, one idle cycle apart, status 01 then 11
    send_burst(32, 2'b01, 2);
    send_burst(32, 2'b11, 2);
    wait_drain("back_to_back");

    // Randomised short bursts with random gaps
    for (int k = 0; k < 4; k++) begin
      send_burst(int'($urandom_range(1, 8)), 2'($urandom), 2);
      repeat (int'($urandom_range(1, 60))) @(negedge clk);
    end
    wait_drain("random_bursts");

    // Overflow: 70 consecutive bytes
    send_burst(70, 2'b00, 2);
    repeat (2) @(negedge clk);
    check("overflow_set", 32'(overflow), 32'h1);
    wait_drain("overflow");
    check("overflow_sticky", 32'(overflow), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
